// File: rtl/hicore_rob.sv
// hicore_rob: in-order reorder buffer. Dispatch allocates at the tail,
// execute writes results back out of order by tag, commit retires the head
// once it is complete. A flush empties the buffer in one cycle.
module hicore_rob #(
  parameter int DEPTH    = 8,
  parameter int TAG_W    = 3,
  parameter int RFIDX_W  = 5,
  parameter int REG_W    = 32,
  parameter int CSRIDX_W = 12,
  parameter int PC_W     = 32,
  parameter int EXCP_W   = 4,
  parameter int IRQ_W    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  output logic [TAG_W-1:0]              alloc_tag,
  input  logic                          alloc_rd_need,
  input  logic [RFIDX_W-1:0]            alloc_rd_idx,
  input  logic                          alloc_csr_need,
  input  logic [CSRIDX_W-1:0]           alloc_csr_idx,
  input  logic                          alloc_fence_i_op,
  input  logic                          alloc_mret_op,
  input  logic [PC_W-1:0]               alloc_pc,
  input  logic [IRQ_W-1:0]              alloc_irq,
  input  logic                          wb_valid,
  input  logic [TAG_W-1:0]              wb_tag,
  input  logic [REG_W-1:0]              wb_rd_data,
  input  logic [REG_W-1:0]              wb_csr_data,
  input  logic [PC_W-1:0]               wb_next_pc,
  input  logic [EXCP_W-1:0]             wb_excp,
  input  logic [TAG_W-1:0]              lookup_tag,
  output logic                          lookup_done,
  output logic [REG_W-1:0]              lookup_data,
  input  logic                          rob_valid,
  output logic                          rob_ready,
  output logic                          rob_rd_need,
  output logic [RFIDX_W-1:0]            rob_rd_idx,
  output logic [REG_W-1:0]              rob_rd_data,
  output logic                          rob_csr_need,
  output logic [CSRIDX_W-1:0]           rob_csr_idx,
  output logic [REG_W-1:0]              rob_csr_data,
  output logic                          rob_fence_i_op,
  output logic                          rob_mret_op,
  output logic [PC_W-1:0]               rob_next_pc,
  output logic [PC_W+IRQ_W+EXCP_W-1:0]  rob_info,
  output logic                          rob_empty,
  input  logic                          flush
);

  typedef struct packed {
    logic                rd_need;
    logic [RFIDX_W-1:0]  rd_idx;
    logic                csr_need;
    logic [CSRIDX_W-1:0] csr_idx;
    logic                fence_i_op;
    logic                mret_op;
    logic [PC_W-1:0]     pc;
    logic [IRQ_W-1:0]    irq;
    logic [REG_W-1:0]    rd_data;
    logic [REG_W-1:0]    csr_data;
    logic [PC_W-1:0]     next_pc;
    logic [EXCP_W-1:0]   excp;
  } entry_t;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [TAG_W:0]              head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]            valid_q, valid_d, done_q, done_d;
  entry_t [DEPTH-1:0]          ent_q, ent_d;

  logic [TAG_W-1:0] head_tag, tail_tag;
  logic             full, alloc_fire, commit_fire, wb_fire;
  entry_t           head_ent;

  assign head_tag    = head_q[TAG_W-1:0];
  assign tail_tag    = tail_q[TAG_W-1:0];
  assign full        = (head_tag == tail_tag) && (head_q[TAG_W] != tail_q[TAG_W]);
  assign rob_empty   = (head_q == tail_q);
  assign alloc_ready = ~full;
  assign alloc_tag   = tail_tag;
  assign alloc_fire  = alloc_valid & ~full;
  assign rob_ready   = valid_q[head_tag] & done_q[head_tag];
  assign commit_fire = rob_valid & rob_ready;
  // A same-cycle alloc of the targeted slot wins over the writeback.
  assign wb_fire     = wb_valid & valid_q[wb_tag] & ~(alloc_fire & (wb_tag == tail_tag));

  assign head_ent       = ent_q[head_tag];
  assign rob_rd_need    = head_ent.rd_need;
  assign rob_rd_idx     = head_ent.rd_idx;
  assign rob_rd_data    = head_ent.rd_data;
  assign rob_csr_need   = head_ent.csr_need;
  assign rob_csr_idx    = head_ent.csr_idx;
  assign rob_csr_data   = head_ent.csr_data;
  assign rob_fence_i_op = head_ent.fence_i_op;
  assign rob_mret_op    = head_ent.mret_op;
  assign rob_next_pc    = head_ent.next_pc;
  assign rob_info       = {head_ent.pc, head_ent.irq, head_ent.excp};

  // Operand lookup sees registered state only; no same-cycle wb bypass.
  assign lookup_done = valid_q[lookup_tag] & done_q[lookup_tag];
  assign lookup_data = ent_q[lookup_tag].rd_data;

  // Next-state: writeback, commit and alloc touch distinct fields/slots;
  // flush overrides everything except payload, which is simply left stale.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    done_d  = done_q;
    ent_d   = ent_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
      done_d  = '0;
    end else begin
      if (wb_fire) begin
        ent_d[wb_tag].rd_data  = wb_rd_data;
        ent_d[wb_tag].csr_data = wb_csr_data;
        ent_d[wb_tag].next_pc  = wb_next_pc;
        ent_d[wb_tag].excp     = wb_excp;
        done_d[wb_tag]         = 1'b1;
      end
      if (commit_fire) begin
        valid_d[head_tag] = 1'b0;
        done_d[head_tag]  = 1'b0;
        head_d            = head_q + 1'b1;
      end
      if (alloc_fire) begin
        valid_d[tail_tag]           = 1'b1;
        done_d[tail_tag]            = 1'b0;
        ent_d[tail_tag].rd_need     = alloc_rd_need;
        ent_d[tail_tag].rd_idx      = alloc_rd_idx;
        ent_d[tail_tag].csr_need    = alloc_csr_need;
        ent_d[tail_tag].csr_idx     = alloc_csr_idx;
        ent_d[tail_tag].fence_i_op  = alloc_fence_i_op;
        ent_d[tail_tag].mret_op     = alloc_mret_op;
        ent_d[tail_tag].pc          = alloc_pc;
        ent_d[tail_tag].irq         = alloc_irq;
        tail_d                      = tail_q + 1'b1;
      end
    end
  end

  // State registers; reset clears payload too so outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
      ent_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ent_q   <= ent_d;
    end
  end

endmodule

// File: tb/tb_hicore_rob.sv
// Directed bench for hicore_rob: a vector table for the out-of-order
// completion flow plus hand sequences for full, wrap, flush and lookup.
module tb_hicore_rob;
  localparam int TAG_W = 3, RFIDX_W = 5, REG_W = 32, CSRIDX_W = 12;
  localparam int PC_W = 32, EXCP_W = 4, IRQ_W = 3;

  logic clk = 1'b0, rst;
  logic alloc_valid, alloc_ready, alloc_rd_need, alloc_csr_need;
  logic alloc_fence_i_op, alloc_mret_op;
  logic [TAG_W-1:0] alloc_tag, wb_tag, lookup_tag;
  logic [RFIDX_W-1:0] alloc_rd_idx, rob_rd_idx;
  logic [CSRIDX_W-1:0] alloc_csr_idx, rob_csr_idx;
  logic [PC_W-1:0] alloc_pc, wb_next_pc, rob_next_pc;
  logic [IRQ_W-1:0] alloc_irq;
  logic wb_valid, lookup_done, rob_valid, rob_ready, rob_empty, flush;
  logic [REG_W-1:0] wb_rd_data, wb_csr_data, lookup_data, rob_rd_data, rob_csr_data;
  logic [EXCP_W-1:0] wb_excp;
  logic rob_rd_need, rob_csr_need, rob_fence_i_op, rob_mret_op;
  logic [PC_W+IRQ_W+EXCP_W-1:0] rob_info;

  int n_pass = 0, n_total = 0;

  hicore_rob dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_rd_need(alloc_rd_need), .alloc_rd_idx(alloc_rd_idx),
    .alloc_csr_need(alloc_csr_need), .alloc_csr_idx(alloc_csr_idx),
    .alloc_fence_i_op(alloc_fence_i_op), .alloc_mret_op(alloc_mret_op),
    .alloc_pc(alloc_pc), .alloc_irq(alloc_irq),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_rd_data(wb_rd_data),
    .wb_csr_data(wb_csr_data), .wb_next_pc(wb_next_pc), .wb_excp(wb_excp),
    .lookup_tag(lookup_tag), .lookup_done(lookup_done), .lookup_data(lookup_data),
    .rob_valid(rob_valid), .rob_ready(rob_ready),
    .rob_rd_need(rob_rd_need), .rob_rd_idx(rob_rd_idx), .rob_rd_data(rob_rd_data),
    .rob_csr_need(rob_csr_need), .rob_csr_idx(rob_csr_idx), .rob_csr_data(rob_csr_data),
    .rob_fence_i_op(rob_fence_i_op), .rob_mret_op(rob_mret_op),
    .rob_next_pc(rob_next_pc), .rob_info(rob_info), .rob_empty(rob_empty),
    .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;  logic [31:0] pc;
    logic        wv;  logic [2:0]  wt;  logic [31:0] wd;
    logic        rv;  logic [2:0]  lt;
    logic        e_ready, e_empty; logic [2:0] e_tag;
    logic [31:0] e_pc, e_rd;
    logic        e_ldone; logic [31:0] e_ldata;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Inputs change 1 time unit after the active edge; checks follow 2 later.
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    alloc_valid = 0; alloc_rd_need = 0; alloc_rd_idx = '0; alloc_csr_need = 0;
    alloc_csr_idx = '0; alloc_fence_i_op = 0; alloc_mret_op = 0; alloc_pc = '0;
    alloc_irq = '0; wb_valid = 0; wb_tag = '0; wb_rd_data = '0; wb_csr_data = '0;
    wb_next_pc = '0; wb_excp = '0; lookup_tag = '0; rob_valid = 0; flush = 0;
  endtask

  task automatic do_reset;
    idle(); rst = 1; tick(); tick(); rst = 0; #2;
    chk("rst_alloc_ready", 64'(alloc_ready), 1);
    chk("rst_alloc_tag", 64'(alloc_tag), 0);
    chk("rst_rob_ready", 64'(rob_ready), 0);
    chk("rst_rob_empty", 64'(rob_empty), 1);
    chk("rst_lookup_done", 64'(lookup_done), 0);
    chk("rst_rob_info", 64'(rob_info), 0);
    chk("rst_rob_rd_data", 64'(rob_rd_data), 0);
  endtask

  initial begin
    rst = 1; idle();
    tbl[0]  = '{1, 32'h1000, 0, 0, 0,        0, 2, 0, 1, 0, 32'h0,    32'h0,  0, 32'h0};
    tbl[1]  = '{1, 32'h1004, 0, 0, 0,        0, 2, 0, 0, 1, 32'h1000, 32'h0,  0, 32'h0};
    tbl[2]  = '{1, 32'h1008, 0, 0, 0,        0, 2, 0, 0, 2, 32'h1000, 32'h0,  0, 32'h0};
    tbl[3]  = '{0, 32'h0,    1, 2, 32'h22,   0, 2, 0, 0, 3, 32'h1000, 32'h0,  0, 32'h0};
    tbl[4]  = '{0, 32'h0,    1, 0, 32'h11,   0, 2, 0, 0, 3, 32'h1000, 32'h0,  1, 32'h22};
    tbl[5]  = '{0, 32'h0,    0, 0, 0,        0, 2, 1, 0, 3, 32'h1000, 32'h11, 1, 32'h22};
    tbl[6]  = '{0, 32'h0,    0, 0, 0,        1, 2, 1, 0, 3, 32'h1000, 32'h11, 1, 32'h22};
    tbl[7]  = '{0, 32'h0,    0, 0, 0,        0, 2, 0, 0, 3, 32'h1004, 32'h0,  1, 32'h22};
    tbl[8]  = '{0, 32'h0,    1, 1, 32'h33,   0, 2, 0, 0, 3, 32'h1004, 32'h0,  1, 32'h22};
    tbl[9]  = '{0, 32'h0,    0, 0, 0,        1, 2, 1, 0, 3, 32'h1004, 32'h33, 1, 32'h22};
    tbl[10] = '{0, 32'h0,    0, 0, 0,        1, 2, 1, 0, 3, 32'h1008, 32'h22, 1, 32'h22};
    tbl[11] = '{0, 32'h0,    0, 0, 0,        0, 2, 0, 1, 3, 32'h0,    32'h0,  0, 32'h22};

    // Fill the buffer, reject the ninth alloc.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1; alloc_pc = 32'h100 + 32'(i) * 4; #2;
      chk("fill_tag", 64'(alloc_tag), 64'(i));
      chk("fill_ready", 64'(alloc_ready), 1);
      tick(); idle();
    end
    #2; chk("full_ready", 64'(alloc_ready), 0);
    alloc_valid = 1; alloc_pc = 32'h999; tick(); idle(); #2;
    chk("ninth_tag", 64'(alloc_tag), 0);
    chk("ninth_head_pc", 64'(rob_info[PC_W+IRQ_W+EXCP_W-1 -: PC_W]), 64'h100);

    // Full with head done: commit and alloc together, alloc rejected.
    wb_valid = 1; wb_tag = 0; wb_rd_data = 32'h55; tick(); idle(); #2;
    chk("full_head_ready", 64'(rob_ready), 1);
    chk("full_head_rd", 64'(rob_rd_data), 64'h55);
    alloc_valid = 1; alloc_pc = 32'h200; rob_valid = 1; #2;
    chk("full_commit_alloc_ready", 64'(alloc_ready), 0);
    tick(); idle(); #2;
    chk("after_commit_ready", 64'(alloc_ready), 1);
    chk("after_commit_tag", 64'(alloc_tag), 0);
    chk("after_commit_rob_ready", 64'(rob_ready), 0);
    chk("after_commit_head_pc", 64'(rob_info[PC_W+IRQ_W+EXCP_W-1 -: PC_W]), 64'h104);
    alloc_valid = 1; alloc_pc = 32'h200; tick(); idle(); #2;
    chk("refull_ready", 64'(alloc_ready), 0);
    chk("refull_tag", 64'(alloc_tag), 1);
    lookup_tag = 0; #1;
    chk("realloc_lookup_done", 64'(lookup_done), 0);

    // Out-of-order completion flow from the vector table.
    do_reset();
    for (int r = 0; r < 12; r++) begin
      alloc_valid = tbl[r].av; alloc_pc = tbl[r].pc;
      wb_valid = tbl[r].wv; wb_tag = tbl[r].wt; wb_rd_data = tbl[r].wd;
      rob_valid = tbl[r].rv; lookup_tag = tbl[r].lt; #2;
      chk($sformatf("tbl%0d_rob_ready", r), 64'(rob_ready), 64'(tbl[r].e_ready));
      chk($sformatf("tbl%0d_rob_empty", r), 64'(rob_empty), 64'(tbl[r].e_empty));
      chk($sformatf("tbl%0d_alloc_tag", r), 64'(alloc_tag), 64'(tbl[r].e_tag));
      chk($sformatf("tbl%0d_head_pc", r), 64'(rob_info[PC_W+IRQ_W+EXCP_W-1 -: PC_W]), 64'(tbl[r].e_pc));
      chk($sformatf("tbl%0d_head_rd", r), 64'(rob_rd_data), 64'(tbl[r].e_rd));
      chk($sformatf("tbl%0d_lookup_done", r), 64'(lookup_done), 64'(tbl[r].e_ldone));
      chk($sformatf("tbl%0d_lookup_data", r), 64'(lookup_data), 64'(tbl[r].e_ldata));
      tick(); idle();
    end

    // Wrap: 12 alloc/wb/commit rounds.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      logic [2:0] irq_v;
      logic [3:0] excp_v;
      logic [31:0] pc_v;
      irq_v = 3'(i); excp_v = 4'(i); pc_v = 32'h4000 + 32'(i) * 4;
      alloc_valid = 1; alloc_pc = pc_v; alloc_irq = irq_v; #2;
      chk("wrap_alloc_tag", 64'(alloc_tag), 64'(i % 8));
      tick(); idle();
      wb_valid = 1; wb_tag = 3'(i % 8); wb_excp = excp_v; wb_rd_data = 32'(i);
      tick(); idle(); #2;
      chk("wrap_rob_ready", 64'(rob_ready), 1);
      chk("wrap_rob_info", 64'(rob_info), 64'({pc_v, irq_v, excp_v}));
      rob_valid = 1; tick(); idle();
    end
    #2;
    chk("wrap_empty", 64'(rob_empty), 1);
    chk("wrap_rob_ready_end", 64'(rob_ready), 0);

    // Flush with a pending alloc; a stale writeback afterwards is dropped.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1; alloc_pc = 32'h800 + 32'(i); tick(); idle();
    end
    wb_valid = 1; wb_tag = 1; wb_rd_data = 32'h77; tick(); idle();
    lookup_tag = 1; #2;
    chk("preflush_lookup_done", 64'(lookup_done), 1);
    flush = 1; alloc_valid = 1; alloc_pc = 32'h900; tick(); idle(); #2;
    chk("flush_empty", 64'(rob_empty), 1);
    chk("flush_rob_ready", 64'(rob_ready), 0);
    chk("flush_alloc_tag", 64'(alloc_tag), 0);
    wb_valid = 1; wb_tag = 1; wb_rd_data = 32'h99; tick(); idle();
    lookup_tag = 1; #2;
    chk("stale_wb_lookup_done", 64'(lookup_done), 0);
    chk("stale_wb_empty", 64'(rob_empty), 1);

    // Lookup goes 0 -> 1 only the cycle after the writeback.
    do_reset();
    alloc_valid = 1; tick(); alloc_valid = 1; tick(); idle();
    lookup_tag = 1; #2;
    chk("lookup_before_wb", 64'(lookup_done), 0);
    wb_valid = 1; wb_tag = 1; wb_rd_data = 32'hDEADBEEF; #2;
    chk("lookup_same_cycle_wb", 64'(lookup_done), 0);
    tick(); idle(); lookup_tag = 1; #2;
    chk("lookup_after_wb", 64'(lookup_done), 1);
    chk("lookup_data", 64'(lookup_data), 64'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
